// File: rtl/alu_serial_seq.sv
// Bit-serial 16-bit ALU: one 1-bit slice reused over 16 cycles, LSB first.
// Optional overflow output is enabled by defining ALU_SEQ_OVERFLOW_EN.
module alu_serial_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic        zero
`ifdef ALU_SEQ_OVERFLOW_EN
  ,
  output logic        overflow
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  state_t      state, next_state;
  logic [15:0] a_sr, b_sr;
  logic [14:0] res_sr;
  logic [2:0]  op_r;
  logic        carry;
  logic [3:0]  count;

  logic        accept, last;
  logic [2:0]  slice_op;
  logic        b_in, sum, cout, slice_out, ovf;
  logic [15:0] result_next;

  // Handshake: start is accepted on any edge where the FSM is not in RUN;
  // done pulses for exactly one cycle, and result/zero hold until the next accept.
  assign accept = start && (state != RUN);
  assign last   = (state == RUN) && (count == 4'd15);
  assign busy   = (state == RUN);
  assign done   = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = RUN;
      RUN:     if (count == 4'd15) next_state = DONE;
      DONE:    next_state = start ? RUN : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // One-bit slice: op[2] inverts b and supplies the initial carry-in.
  always_comb begin
    slice_op  = (op_r == OP_SLT) ? OP_SUB : op_r;
    b_in      = b_sr[0] ^ slice_op[2];
    sum       = a_sr[0] ^ b_in ^ carry;
    cout      = (a_sr[0] & b_in) | (carry & (a_sr[0] ^ b_in));
    slice_out = 1'b0;
    case (slice_op[1:0])
      2'b00:   slice_out = a_sr[0] & b_in;
      2'b01:   slice_out = a_sr[0] | b_in;
      2'b10:   slice_out = sum;
      default: slice_out = 1'b0;
    endcase
    // On the last bit, carry holds the carry into bit 15.
    ovf         = carry ^ cout;
    result_next = (op_r == OP_SLT) ? {15'b0, sum ^ ovf} : {slice_out, res_sr};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      op_r   <= '0;
      carry  <= 1'b0;
      count  <= '0;
      result <= '0;
      zero   <= 1'b1;
`ifdef ALU_SEQ_OVERFLOW_EN
      overflow <= 1'b0;
`endif
    end else if (accept) begin
      a_sr  <= a;
      b_sr  <= b;
      op_r  <= op;
      carry <= op[2];
      count <= '0;
    end else if (state == RUN) begin
      a_sr   <= {1'b0, a_sr[15:1]};
      b_sr   <= {1'b0, b_sr[15:1]};
      res_sr <= {slice_out, res_sr[14:1]};
      carry  <= cout;
      count  <= count + 4'd1;
      if (last) begin
        result <= result_next;
        zero   <= (result_next == 16'd0);
`ifdef ALU_SEQ_OVERFLOW_EN
        overflow <= ((op_r == OP_ADD) || (op_r == OP_SUB)) ? ovf : 1'b0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_alu_serial_seq.sv
// Directed scoreboard bench for alu_serial_seq; expected results are hand-computed.
module tb_alu_serial_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        busy, done, zero;
  logic [15:0] result;
`ifdef ALU_SEQ_OVERFLOW_EN
  logic        overflow;
`endif

  alu_serial_seq dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .zero(zero)
`ifdef ALU_SEQ_OVERFLOW_EN
    , .overflow(overflow)
`endif
  );

  always #5 clk = ~clk;

  // Scoreboard entry: {overflow, zero, result}
  logic [17:0] exp_q[$];
  int pass_cnt = 0;
  int total_cnt = 0;
  int done_cnt = 0;
  int issued = 0;
  int busy_len = 0;
  logic prev_done = 1'b0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else pass_cnt++;
  endtask

  // Monitor: compares every done pulse against the head of the queue.
  always @(negedge clk) begin
    logic [17:0] e;
    if (reset) begin
      busy_len  = 0;
      prev_done = 1'b0;
    end else begin
      if (done) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          total_cnt++;
          $display("FAIL unexpected_done: got result %h with no operation pending", result);
        end else begin
          e = exp_q.pop_front();
          check("result", result, e[15:0]);
          check("zero", {15'b0, zero}, {15'b0, e[16]});
`ifdef ALU_SEQ_OVERFLOW_EN
          check("overflow", {15'b0, overflow}, {15'b0, e[17]});
`endif
          check("busy_len", busy_len[15:0], 16'd16);
          check("done_pulse", {15'b0, prev_done}, 16'd0);
        end
        busy_len = 0;
      end
      if (busy) busy_len++;
      prev_done = done;
    end
  end

  task automatic start_op(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y,
                          input logic [15:0] r, input logic ov, input bit push);
    if (push) begin
      exp_q.push_back({ov, (r == 16'd0), r});
      issued++;
    end
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    op = 3'($urandom_range(0, 7));
    a = 16'($urandom_range(0, 65535));
    b = 16'($urandom_range(0, 65535));
  endtask

  task automatic wait_not_busy();
    int i;
    for (i = 0; i < 40; i++) begin
      if (!busy) break;
      @(posedge clk); #1;
    end
    if (busy) check("busy_timeout", {15'b0, busy}, 16'd0);
  endtask

  task automatic run(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y,
                     input logic [15:0] r, input logic ov);
    wait_not_busy();
    start_op(o, x, y, r, ov, 1'b1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {15'b0, busy}, 16'd0);
    check("rst_done", {15'b0, done}, 16'd0);
    check("rst_result", result, 16'h0000);
    check("rst_zero", {15'b0, zero}, 16'd1);
    reset = 1'b0;
    @(posedge clk); #1;

    run(3'b010, 16'h7FFF, 16'h0001, 16'h8000, 1'b1);
    run(3'b110, 16'h0005, 16'h0007, 16'hFFFE, 1'b0);
    run(3'b110, 16'h1234, 16'h1234, 16'h0000, 1'b0);
    run(3'b111, 16'hFFFF, 16'h0001, 16'h0001, 1'b0);
    run(3'b111, 16'h8000, 16'h0001, 16'h0001, 1'b0);
    run(3'b111, 16'h0003, 16'h0003, 16'h0000, 1'b0);
    run(3'b111, 16'h7FFF, 16'h8000, 16'h0000, 1'b0);
    run(3'b010, 16'hFFFF, 16'h0001, 16'h0000, 1'b0);
    run(3'b101, 16'h0F0F, 16'hFFFF, 16'h0F0F, 1'b0);
    run(3'b011, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0);

    // Back-to-back: second start held during the done cycle
    run(3'b000, 16'hF0F0, 16'hFF00, 16'hF000, 1'b0);
    for (int i = 0; i < 40; i++) begin
      if (done) break;
      @(posedge clk); #1;
    end
    check("b2b_done_seen", {15'b0, done}, 16'd1);
    start_op(3'b001, 16'hF0F0, 16'hFF00, 16'hFFF0, 1'b0, 1'b1);
    check("b2b_busy", {15'b0, busy}, 16'd1);

    // start during RUN must be ignored
    run(3'b010, 16'h1234, 16'h1111, 16'h2345, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    op = 3'b010; a = 16'hFFFF; b = 16'hFFFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_not_busy();
    repeat (30) @(posedge clk);
    #1;
    check("no_extra_op", 16'(done_cnt), 16'(issued));

    // Reset in the middle of RUN aborts the operation
    start_op(3'b110, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0);
    repeat (7) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("abort_busy", {15'b0, busy}, 16'd0);
    check("abort_done", {15'b0, done}, 16'd0);
    check("abort_result", result, 16'h0000);
    check("abort_zero", {15'b0, zero}, 16'd1);
    reset = 1'b0;
    @(posedge clk); #1;

    run(3'b100, 16'hFFFF, 16'h00FF, 16'hFF00, 1'b0);
    for (int i = 0; i < 60; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk); #1;
    end
    check("queue_drained", 16'(exp_q.size()), 16'd0);
    repeat (3) @(posedge clk);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
